// File: rtl/sonic_constants.sv
// rtl/sonic_constants.sv - shared register address map for the sonic PCIe block
// Purpose: register addresses decoded by the sonic register clients.
// Ports: none (package).
package sonic_constants;

   localparam logic [7:0] SONIC_REG_CNTL_DW0 = 8'h20;
   localparam logic [7:0] SONIC_REG_CNTL_DW1 = 8'h21;
   localparam logic [7:0] SONIC_REG_CNTL_DW2 = 8'h22;
   localparam logic [7:0] SONIC_REG_CNTL_DW3 = 8'h23;

endpackage

// File: rtl/sonic_irq_pkg.sv
// rtl/sonic_irq_pkg.sv - types and constants for the sonic interrupt generator
// Purpose: FSM state encoding, CNTL_DW0 field positions and TLP fmt bytes.
// Ports: none (package).
package sonic_irq_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      START_TX = 2'd1,
      MWR_REQ  = 2'd2,
      MWR_DV   = 2'd3
   } irq_state_e;

   localparam int DW0_EN_BIT     = 0;
   localparam int DW0_THRESH_LSB = 8;
   localparam int DW0_THRESH_W   = 8;

   localparam logic [7:0] FMT_4DW_MWR = 8'h60;
   localparam logic [7:0] FMT_3DW_MWR = 8'h40;

endpackage

// File: rtl/sonic_irq_prg_reg.sv
// rtl/sonic_irq_prg_reg.sv - CNTL_DW0..DW3 register file for the interrupt generator
// Purpose: captures irq_prg_* writes and decodes the DW0 fields.
// Ports:
//   clk_in, rstn                       clock, async active-low reset
//   irq_prg_wrena/wrdata/addr          register write port
//   irq_en, thresh                     DW0 fields (thresh 0 reads back as 1)
//   addr_lo, addr_hi                   DW1/DW2 interrupt target address
//   rx_block_size                      DW3 contents
module sonic_irq_prg_reg
   import sonic_constants::*;
   import sonic_irq_pkg::*;
(
   input  logic        clk_in,
   input  logic        rstn,
   input  logic        irq_prg_wrena,
   input  logic [31:0] irq_prg_wrdata,
   input  logic [7:0]  irq_prg_addr,
   output logic        irq_en,
   output logic [7:0]  thresh,
   output logic [31:0] addr_lo,
   output logic [31:0] addr_hi,
   output logic [31:0] rx_block_size
);

   logic       irq_en_q;
   logic [7:0] thresh_q;

   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) begin
         irq_en_q      <= 1'b0;
         thresh_q      <= 8'h0;
         addr_lo       <= 32'h0;
         addr_hi       <= 32'h0;
         rx_block_size <= 32'h0;
      end else if (irq_prg_wrena) begin
         case (irq_prg_addr)
            SONIC_REG_CNTL_DW0: begin
               irq_en_q <= irq_prg_wrdata[DW0_EN_BIT];
               thresh_q <= irq_prg_wrdata[DW0_THRESH_LSB +: DW0_THRESH_W];
            end
            SONIC_REG_CNTL_DW1: addr_lo       <= irq_prg_wrdata;
            SONIC_REG_CNTL_DW2: addr_hi       <= irq_prg_wrdata;
            SONIC_REG_CNTL_DW3: rx_block_size <= irq_prg_wrdata;
            default: ;
         endcase
      end
   end

   assign irq_en = irq_en_q;
   // A zero threshold would fire with nothing to report, so it acts as 1.
   assign thresh = (thresh_q == 8'h0) ? 8'h1 : thresh_q;

endmodule

// File: rtl/sonic_irq_gen.sv
// rtl/sonic_irq_gen.sv - coalescing MSI-style interrupt generator over the shared TX backend
// Purpose: counts completed RX blocks and, once a batch threshold is reached,
//   issues one single-beat PCIe memory write carrying {0, block_size, reported, seq}.
// Optional feature: SONIC_IRQ_TIMEOUT_EN flushes a partial batch after TIMEOUT_CYCLES idle cycles.
// Ports:
//   clk_in, rstn                                 clock, async active-low reset
//   irq_prg_wrena/wrdata/addr                    register writes from sonic_cmd_ctl
//   rx_block_done                                one pulse per completed RX block
//   rx_block_size, irq_count                     DW3 export, interrupts issued
//   tx_req/desc/dv/dfr/data/err, tx_ack/ws       PCIe TX backend
//   tx_sel, tx_ready_others, tx_busy, tx_ready   TX arbitration
module sonic_irq_gen
   import sonic_irq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 125000,
   parameter int PEND_WIDTH     = 16
)(
   input  logic         clk_in,
   input  logic         rstn,
   input  logic         irq_prg_wrena,
   input  logic [31:0]  irq_prg_wrdata,
   input  logic [7:0]   irq_prg_addr,
   input  logic         rx_block_done,
   output logic [31:0]  rx_block_size,
   output logic [31:0]  irq_count,
   output logic         tx_req,
   output logic [127:0] tx_desc,
   output logic         tx_dv,
   output logic         tx_dfr,
   output logic [127:0] tx_data,
   output logic         tx_err,
   input  logic         tx_ack,
   input  logic         tx_ws,
   input  logic         tx_sel,
   input  logic         tx_ready_others,
   output logic         tx_busy,
   output logic         tx_ready
);

   logic                  irq_en;
   logic [7:0]            thresh;
   logic [31:0]           addr_lo, addr_hi;

   irq_state_e            state_q, state_d;
   logic [PEND_WIDTH-1:0] pending_q, reported_q, thresh_w, rep_now;
   logic [PEND_WIDTH:0]   pend_sum;
   logic [31:0]           seq_q, irq_count_q;
   logic [127:0]          desc_q, data_q, desc_d;
   logic                  latch_desc, tx_accept;
   logic                  addr_ok, batch_fire, timeout_fire, fire;

   sonic_irq_prg_reg u_prg_reg (
      .clk_in         (clk_in),
      .rstn           (rstn),
      .irq_prg_wrena  (irq_prg_wrena),
      .irq_prg_wrdata (irq_prg_wrdata),
      .irq_prg_addr   (irq_prg_addr),
      .irq_en         (irq_en),
      .thresh         (thresh),
      .addr_lo        (addr_lo),
      .addr_hi        (addr_hi),
      .rx_block_size  (rx_block_size)
   );

   assign thresh_w   = PEND_WIDTH'(thresh);
   assign rep_now    = (pending_q < thresh_w) ? pending_q : thresh_w;
   // The write must target a non-null, DW-aligned address.
   assign addr_ok    = ({addr_hi, addr_lo} != 64'h0) && (addr_lo[1:0] == 2'b00);
   assign batch_fire = irq_en && (pending_q >= thresh_w) && addr_ok;
   assign fire       = batch_fire || timeout_fire;

`ifdef SONIC_IRQ_TIMEOUT_EN
   logic [31:0] idle_cnt_q;
   logic        waiting;

   assign waiting      = (state_q == IDLE) && (pending_q != '0) && (pending_q < thresh_w) && irq_en;
   assign timeout_fire = waiting && addr_ok && !rx_block_done &&
                         (idle_cnt_q == 32'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn)
         idle_cnt_q <= 32'h0;
      else if (rx_block_done || fire || !waiting)
         idle_cnt_q <= 32'h0;
      else
         idle_cnt_q <= idle_cnt_q + 32'h1;
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timeout_fire       = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      tx_ready   = 1'b0;
      tx_req     = 1'b0;
      tx_dv      = 1'b0;
      tx_busy    = 1'b0;
      latch_desc = 1'b0;
      tx_accept  = 1'b0;
      case (state_q)
         IDLE:     if (fire) state_d = START_TX;
         START_TX: begin
            tx_ready = 1'b1;
            if (tx_sel && !tx_ws && !tx_ready_others) begin
               latch_desc = 1'b1;
               state_d    = MWR_REQ;
            end
         end
         MWR_REQ: begin
            tx_req  = 1'b1;
            tx_busy = 1'b1;
            if (tx_ack) begin
               tx_accept = 1'b1;
               state_d   = MWR_DV;
            end
         end
         MWR_DV: begin
            tx_dv   = 1'b1;
            tx_busy = 1'b1;
            if (!tx_ws) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      desc_d            = 128'h0;
      desc_d[127:120]   = (addr_hi != 32'h0) ? FMT_4DW_MWR : FMT_3DW_MWR;
      desc_d[105:96]    = 10'd4;
      desc_d[79:72]     = 8'h00;
      desc_d[71:64]     = 8'hFF;
      desc_d[63:0]      = {addr_hi, addr_lo};
   end

   // reported never exceeds pending, so the sum cannot underflow; bit PEND_WIDTH
   // flags an increment past the counter's ceiling.
   assign pend_sum = {1'b0, pending_q} + (PEND_WIDTH+1)'(rx_block_done)
                   - (tx_accept ? {1'b0, reported_q} : '0);

   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         reported_q  <= '0;
         seq_q       <= 32'h0;
         irq_count_q <= 32'h0;
         desc_q      <= 128'h0;
         data_q      <= 128'h0;
      end else begin
         state_q   <= state_d;
         pending_q <= pend_sum[PEND_WIDTH] ? '1 : pend_sum[PEND_WIDTH-1:0];
         if (latch_desc) begin
            desc_q     <= desc_d;
            data_q     <= {32'h0, rx_block_size, 32'(rep_now), seq_q};
            reported_q <= rep_now;
         end
         if (tx_accept) begin
            seq_q       <= seq_q + 32'h1;
            irq_count_q <= irq_count_q + 32'h1;
         end
      end
   end

   assign tx_desc   = desc_q;
   assign tx_data   = data_q;
   assign tx_dfr    = 1'b0;
   assign tx_err    = 1'b0;
   assign irq_count = irq_count_q;

endmodule

// File: tb/tb_sonic_irq_gen.sv
// tb/tb_sonic_irq_gen.sv - self-checking bench for sonic_irq_gen
module tb_sonic_irq_gen;
   import sonic_constants::*;

   logic         clk_in, rstn;
   logic         irq_prg_wrena;
   logic [31:0]  irq_prg_wrdata;
   logic [7:0]   irq_prg_addr;
   logic         rx_block_done;
   logic [31:0]  rx_block_size, irq_count;
   logic         tx_req, tx_dv, tx_dfr, tx_err, tx_busy, tx_ready;
   logic [127:0] tx_desc, tx_data;
   logic         tx_ack, tx_ws, tx_sel, tx_ready_others;

   int total = 0;
   int bad   = 0;

   int          m_pending, m_seq, m_cnt, m_thresh;
   bit          m_en;
   logic [31:0] m_lo, m_hi, m_size;

   sonic_irq_gen #(.TIMEOUT_CYCLES(100), .PEND_WIDTH(16)) dut (
      .clk_in(clk_in), .rstn(rstn),
      .irq_prg_wrena(irq_prg_wrena), .irq_prg_wrdata(irq_prg_wrdata), .irq_prg_addr(irq_prg_addr),
      .rx_block_done(rx_block_done), .rx_block_size(rx_block_size), .irq_count(irq_count),
      .tx_req(tx_req), .tx_desc(tx_desc), .tx_dv(tx_dv), .tx_dfr(tx_dfr), .tx_data(tx_data),
      .tx_err(tx_err), .tx_ack(tx_ack), .tx_ws(tx_ws), .tx_sel(tx_sel),
      .tx_ready_others(tx_ready_others), .tx_busy(tx_busy), .tx_ready(tx_ready)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask

   function automatic int eff_thresh();
      return (m_thresh == 0) ? 1 : m_thresh;
   endfunction

   task automatic apply_reset;
      rstn = 1'b0;
      irq_prg_wrena = 1'b0; irq_prg_wrdata = 32'h0; irq_prg_addr = 8'h0;
      rx_block_done = 1'b0; tx_ack = 1'b0; tx_ws = 1'b0; tx_sel = 1'b0; tx_ready_others = 1'b0;
      repeat (2) tick;
      rstn = 1'b1;
      tick;
      m_pending = 0; m_seq = 0; m_cnt = 0; m_thresh = 0; m_en = 0;
      m_lo = 0; m_hi = 0; m_size = 0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      irq_prg_wrena = 1'b1; irq_prg_addr = a; irq_prg_wrdata = d;
      tick;
      irq_prg_wrena = 1'b0;
      case (a)
         SONIC_REG_CNTL_DW0: begin m_en = d[0]; m_thresh = int'(d[15:8]); end
         SONIC_REG_CNTL_DW1: m_lo = d;
         SONIC_REG_CNTL_DW2: m_hi = d;
         SONIC_REG_CNTL_DW3: m_size = d;
         default: ;
      endcase
   endtask

   task automatic cfg(input int thr, input bit en, input logic [31:0] lo, input logic [31:0] hi,
                      input logic [31:0] size);
      logic [7:0] t8;
      t8 = thr[7:0];
      wr(SONIC_REG_CNTL_DW1, lo);
      wr(SONIC_REG_CNTL_DW2, hi);
      wr(SONIC_REG_CNTL_DW3, size);
      wr(SONIC_REG_CNTL_DW0, {16'h0, t8, 7'h0, en});
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         rx_block_done = 1'b1;
         tick;
         rx_block_done = 1'b0;
         m_pending++;
         tick;
      end
   endtask

   task automatic expect_quiet(input int cycles, input string name);
      bit seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         if (tx_ready || tx_req) seen = 1;
         tick;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL %s: interrupt request seen, required none", name);
      end
   endtask

   // Completes one interrupt transaction as the arbiter/backend and checks it
   // against the model; pulse_on_ack drives rx_block_done during the ack cycle.
   task automatic serve(input int ws, input bit pulse_on_ack, input string name);
      int           rep, w;
      logic [127:0] exp_desc, exp_data;
      logic [31:0]  rep32, seq32;
      w = 0;
      while (!tx_ready && w < 300) begin tick; w++; end
      total++;
      if (!tx_ready) begin
         bad++;
         $display("FAIL %s wait_ready: tx_ready=0 after %0d cycles, required 1", name, w);
         return;
      end
      rep      = (m_pending < eff_thresh()) ? m_pending : eff_thresh();
      rep32    = rep;
      seq32    = m_seq;
      exp_desc = 128'h0;
      exp_desc[127:120] = (m_hi != 0) ? 8'h60 : 8'h40;
      exp_desc[105:96]  = 10'd4;
      exp_desc[71:64]   = 8'hFF;
      exp_desc[63:0]    = {m_hi, m_lo};
      exp_data = {32'h0, m_size, rep32, seq32};

      tx_sel = 1'b1;
      tick;
      tx_sel = 1'b0;
      total++;
      if ({tx_req, tx_busy, tx_ready, tx_dv} !== 4'b1100) begin
         bad++;
         $display("FAIL %s req_phase: req/busy/ready/dv=%b required 1100", name,
                  {tx_req, tx_busy, tx_ready, tx_dv});
      end
      total++;
      if (tx_desc !== exp_desc) begin
         bad++;
         $display("FAIL %s desc: got %h required %h", name, tx_desc, exp_desc);
      end
      total++;
      if (tx_data !== exp_data) begin
         bad++;
         $display("FAIL %s data: got %h required %h", name, tx_data, exp_data);
      end

      tx_ack = 1'b1;
      rx_block_done = pulse_on_ack;
      tick;
      tx_ack = 1'b0;
      rx_block_done = 1'b0;
      m_pending = m_pending - rep + (pulse_on_ack ? 1 : 0);
      m_seq++;
      m_cnt++;
      total++;
      if ({tx_dv, tx_req, tx_busy, tx_dfr, tx_err} !== 5'b10100) begin
         bad++;
         $display("FAIL %s dv_phase: dv/req/busy/dfr/err=%b required 10100", name,
                  {tx_dv, tx_req, tx_busy, tx_dfr, tx_err});
      end
      total++;
      if (irq_count !== 32'(m_cnt)) begin
         bad++;
         $display("FAIL %s irq_count: got %0d required %0d", name, irq_count, m_cnt);
      end

      if (ws > 0) begin
         tx_ws = 1'b1;
         for (int k = 0; k < ws; k++) begin
            tick;
            total++;
            if ({tx_dv, tx_desc, tx_data} !== {1'b1, exp_desc, exp_data}) begin
               bad++;
               $display("FAIL %s ws_hold%0d: dv=%b desc=%h data=%h", name, k, tx_dv, tx_desc, tx_data);
            end
         end
         tx_ws = 1'b0;
      end
      tick;
      total++;
      if ({tx_dv, tx_busy} !== 2'b00) begin
         bad++;
         $display("FAIL %s idle_return: dv/busy=%b required 00", name, {tx_dv, tx_busy});
      end
   endtask

   task automatic test_reset;
      apply_reset;
      total++;
      if ({tx_req, tx_dv, tx_busy, tx_ready, tx_dfr, tx_err} !== 6'b0 || irq_count !== 32'h0 ||
          rx_block_size !== 32'h0) begin
         bad++;
         $display("FAIL reset_state: tx flags=%b irq_count=%0d size=%h required all 0",
                  {tx_req, tx_dv, tx_busy, tx_ready, tx_dfr, tx_err}, irq_count, rx_block_size);
      end
      wr(SONIC_REG_CNTL_DW3, 32'h0000_1234);
      wr(8'hFF, 32'hDEAD_BEEF);
      total++;
      if (rx_block_size !== m_size) begin
         bad++;
         $display("FAIL reg_decode: rx_block_size=%h required %h", rx_block_size, m_size);
      end
   endtask

   task automatic test_single;
      apply_reset;
      cfg(1, 1, 32'h1000_0040, 32'h0, 32'h0);
      pulses(1);
      serve(0, 0, "single_3dw");
   endtask

   task automatic test_batch;
      apply_reset;
      cfg(4, 1, 32'h0000_0100, 32'h1, 32'h200);
      pulses(10);
      serve(0, 0, "batch_first");
      serve(0, 0, "batch_second");
      expect_quiet(10, "batch_remainder_quiet");
      wr(SONIC_REG_CNTL_DW0, 32'h0000_0201);
      serve(0, 0, "batch_remainder");
   endtask

   task automatic test_ws_stall;
      apply_reset;
      cfg(2, 1, 32'h0000_8000, 32'h0, 32'h55);
      pulses(2);
      serve(5, 0, "ws_stall");
   endtask

   task automatic test_back_to_back;
      apply_reset;
      cfg(4, 1, 32'h0000_0400, 32'h0, 32'h10);
      pulses(4);
      serve(0, 1, "ack_overlap");
      expect_quiet(10, "ack_overlap_quiet");
      wr(SONIC_REG_CNTL_DW0, 32'h0000_0101);
      serve(0, 0, "ack_overlap_leftover");
   endtask

   task automatic test_addr_gate;
      apply_reset;
      cfg(2, 1, 32'h0, 32'h0, 32'h77);
      pulses(3);
      expect_quiet(10, "null_addr_quiet");
      wr(SONIC_REG_CNTL_DW1, 32'h0000_2001);
      expect_quiet(10, "unaligned_addr_quiet");
      wr(SONIC_REG_CNTL_DW1, 32'h0000_2000);
      serve(0, 0, "addr_valid_fire");
   endtask

   task automatic test_thresh_zero;
      apply_reset;
      cfg(0, 1, 32'h0000_3000, 32'h0, 32'h1);
      pulses(1);
      serve(0, 0, "thresh_zero");
   endtask

   task automatic test_disabled;
      apply_reset;
      cfg(2, 0, 32'h0000_4000, 32'h0, 32'h2);
      pulses(5);
      expect_quiet(10, "disabled_quiet");
      wr(SONIC_REG_CNTL_DW0, 32'h0000_0201);
      serve(0, 0, "enable_first");
      serve(0, 0, "enable_second");
      expect_quiet(10, "enable_remainder_quiet");
   endtask

   task automatic test_reset_mid;
      apply_reset;
      cfg(1, 1, 32'h0000_5000, 32'h0, 32'h3);
      pulses(1);
      tx_sel = 1'b1;
      tick;
      tx_sel = 1'b0;
      #2 rstn = 1'b0;
      #1;
      total++;
      if ({tx_req, tx_dv, tx_busy, tx_ready} !== 4'b0) begin
         bad++;
         $display("FAIL reset_mid_async: req/dv/busy/ready=%b required 0000",
                  {tx_req, tx_dv, tx_busy, tx_ready});
      end
      tick;
      rstn = 1'b1;
      tick;
      total++;
      if (irq_count !== 32'h0) begin
         bad++;
         $display("FAIL reset_mid_count: irq_count=%0d required 0", irq_count);
      end
      expect_quiet(10, "reset_mid_no_retry");
   endtask

   task automatic test_timeout;
      int n;
      apply_reset;
      cfg(8, 1, 32'h0000_6000, 32'h0, 32'h4);
      pulses(2);
      rx_block_done = 1'b1;
      tick;
      rx_block_done = 1'b0;
      m_pending++;
`ifdef SONIC_IRQ_TIMEOUT_EN
      n = 0;
      while (!tx_ready && n < 300) begin tick; n++; end
      total++;
      if (n != 100) begin
         bad++;
         $display("FAIL timeout_latency: tx_ready after %0d cycles, required 100", n);
      end
      serve(0, 0, "timeout_flush");
`else
      n = 0;
      expect_quiet(300, "timeout_disabled_quiet");
`endif
   endtask

   task automatic test_random;
      int thr, n, guard;
      logic [31:0] lo, hi;
      apply_reset;
      for (int it = 0; it < 8; it++) begin
         thr = $urandom_range(1, 6);
         hi  = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
         lo  = ($urandom | 32'h4) & 32'hFFFF_FFFC;
         cfg(thr, 1, lo, hi, $urandom);
         n = $urandom_range(0, 12);
         pulses(n);
         guard = 0;
         while (m_pending >= eff_thresh() && guard < 20) begin
            serve($urandom_range(0, 3), 0, "random");
            guard++;
         end
         expect_quiet(4, "random_quiet");
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_batch;
      test_ws_stall;
      test_back_to_back;
      test_addr_gate;
      test_thresh_zero;
      test_disabled;
      test_reset_mid;
      test_timeout;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
